// File: rtl/dpsram_fwd.sv
// Simple dual-port SRAM (1R/1W) with byte-lane strobes, write-first collision
// forwarding, 1- or 2-cycle read latency and an optional post-reset clear engine.
//
// state | meaning
// CLEAR | sweeping the array with zeros, ports ignored, init_busy=1
// RUN   | normal operation until next reset
module dpsram_fwd #(
  parameter int A    = 16,
  parameter int D    = 32,
  parameter int S    = 2,
  parameter int L    = 1,
  parameter int INIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ren,
  input  logic [A-1:0] raddr,
  output logic [D-1:0] rdata,
  output logic         rvalid,
  input  logic         wen,
  input  logic [A-1:0] waddr,
  input  logic [D-1:0] wdata,
  input  logic [S-1:0] wstrb,
  output logic         init_busy
);

  localparam int E = D / S;

  generate
    if ((D % S) != 0 || (L != 1 && L != 2)) begin : g_bad_param
      $error("dpsram_fwd: D must be a multiple of S and L must be 1 or 2");
    end
  endgenerate

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t         state_q, state_d;
  logic [A-1:0]   cnt_q, cnt_d;
  logic           clr_we;
  logic           ren_act, wen_act;
  logic [D-1:0]   fwd_data;
  logic           rd_vld_d;
  logic [D-1:0]   rd_data_d;
  logic           rvalid_q;
  logic [D-1:0]   rdata_q;
  logic [D-1:0]   mem_q [2**A];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (INIT != 0) ? ST_CLEAR : ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_RUN;
      end
      default: ;
    endcase
  end

  assign init_busy = (state_q == ST_CLEAR);
  assign ren_act   = ren & ~init_busy;
  assign wen_act   = wen & ~init_busy;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[cnt_q] <= '0;
    end else if (wen_act) begin
      for (int i = 0; i < S; i++)
        if (wstrb[i]) mem_q[waddr][i*E +: E] <= wdata[i*E +: E];
    end
  end

  // Write-first per lane: strobed lanes of a same-address write override the stored word.
  always_comb begin
    fwd_data = mem_q[raddr];
    for (int i = 0; i < S; i++)
      if (wen_act && (waddr == raddr) && wstrb[i]) fwd_data[i*E +: E] = wdata[i*E +: E];
  end

  generate
    if (L == 2) begin : g_lat2
      logic         s1_vld_q;
      logic [D-1:0] s1_data_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_vld_q  <= 1'b0;
          s1_data_q <= '0;
        end else begin
          s1_vld_q <= ren_act;
          if (ren_act) s1_data_q <= fwd_data;
        end
      end
      assign rd_vld_d  = s1_vld_q;
      assign rd_data_d = s1_data_q;
    end else begin : g_lat1
      assign rd_vld_d  = ren_act;
      assign rd_data_d = fwd_data;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_vld_d;
      if (rd_vld_d) rdata_q <= rd_data_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_dpsram_fwd.sv
// Directed bench for dpsram_fwd: one L=1 and one L=2 instance driven by the same
// stimulus, checked against hand-computed per-cycle vectors and reset/clear sequences.
module tb_dpsram_fwd;

  logic        clk, rst_n;
  logic        ren, wen;
  logic [3:0]  raddr, waddr;
  logic [31:0] wdata;
  logic [1:0]  wstrb;
  logic [31:0] rdata1, rdata2;
  logic        rvalid1, rvalid2, busy1, busy2;

  int total = 0;
  int bad   = 0;

  dpsram_fwd #(.A(4), .D(32), .S(2), .L(1), .INIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ren(ren), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .init_busy(busy1));

  dpsram_fwd #(.A(4), .D(32), .S(2), .L(2), .INIT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .ren(ren), .raddr(raddr), .rdata(rdata2), .rvalid(rvalid2),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .init_busy(busy2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        ren;
    logic [3:0]  raddr;
    logic        wen;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  wstrb;
    logic        rv1;
    logic [31:0] rd1;
    logic        rv2;
    logic [31:0] rd2;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] ra, input logic w, input logic [3:0] wa,
                     input logic [31:0] wd, input logic [1:0] ws,
                     input logic rv1, input logic [31:0] rd1, input logic rv2, input logic [31:0] rd2);
    vec_t v;
    v.ren = r; v.raddr = ra; v.wen = w; v.waddr = wa; v.wdata = wd; v.wstrb = ws;
    v.rv1 = rv1; v.rd1 = rd1; v.rv2 = rv2; v.rd2 = rd2;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ren = 1'b0; raddr = '0; wen = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
  endtask

  // Releases reset with read/write attempts on address 2 held during the clear.
  task automatic release_and_clear(input string nm);
    int n;
    ren = 1'b1; raddr = 4'd2; wen = 1'b1; waddr = 4'd2; wdata = 32'hFFFF_FFFF; wstrb = 2'b11;
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      chk($sformatf("%s_rv1_c%0d", nm, n), {31'd0, rvalid1}, 32'd0);
      chk($sformatf("%s_rv2_c%0d", nm, n), {31'd0, rvalid2}, 32'd0);
    end while (busy1 && n < 100);
    idle_inputs();
    chk({nm, "_busy_cycles"}, n, 32'd16);
    chk({nm, "_busy2_low"}, {31'd0, busy2}, 32'd0);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      @(negedge clk);
      ren = vecs[k].ren; raddr = vecs[k].raddr; wen = vecs[k].wen;
      waddr = vecs[k].waddr; wdata = vecs[k].wdata; wstrb = vecs[k].wstrb;
      @(posedge clk); #1;
      chk($sformatf("row%0d_rv1", k), {31'd0, rvalid1}, {31'd0, vecs[k].rv1});
      chk($sformatf("row%0d_rd1", k), rdata1, vecs[k].rd1);
      chk($sformatf("row%0d_rv2", k), {31'd0, rvalid2}, {31'd0, vecs[k].rv2});
      chk($sformatf("row%0d_rd2", k), rdata2, vecs[k].rd2);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Rows 0..17: sweep all 16 cleared words (L=2 column lags one row).
    for (int i = 0; i < 16; i++)
      add(1, 4'(i), 0, 0, 0, 0, 1, 0, (i != 0), 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Rows 18..24: lane strobes on word 5, zero-strobe collision.
    add(0, 0, 1, 5, 32'hAABB_CCDD, 2'b01, 0, 0, 0, 0);
    add(1, 5, 0, 0, 0, 0, 1, 32'h0000_CCDD, 0, 0);
    add(0, 0, 1, 5, 32'h1122_3344, 2'b10, 0, 32'h0000_CCDD, 1, 32'h0000_CCDD);
    add(1, 5, 0, 0, 0, 0, 1, 32'h1122_CCDD, 0, 32'h0000_CCDD);
    add(0, 0, 0, 0, 0, 0, 0, 32'h1122_CCDD, 1, 32'h1122_CCDD);
    add(1, 5, 1, 5, 32'hFFFF_FFFF, 2'b00, 1, 32'h1122_CCDD, 0, 32'h1122_CCDD);
    add(0, 0, 1, 7, 32'h1111_2222, 2'b11, 0, 32'h1122_CCDD, 1, 32'h1122_CCDD);
    // Rows 25..27: partial-strobe collision on word 7.
    add(1, 7, 1, 7, 32'h3333_4444, 2'b10, 1, 32'h3333_2222, 0, 32'h1122_CCDD);
    add(1, 7, 0, 0, 0, 0, 1, 32'h3333_2222, 1, 32'h3333_2222);
    add(0, 0, 0, 0, 0, 0, 0, 32'h3333_2222, 1, 32'h3333_2222);
    // Rows 28..30: read and write to different addresses in the same cycle.
    add(1, 5, 1, 6, 32'hCAFE_BABE, 2'b11, 1, 32'h1122_CCDD, 0, 32'h3333_2222);
    add(1, 6, 0, 0, 0, 0, 1, 32'hCAFE_BABE, 1, 32'h1122_CCDD);
    add(0, 0, 0, 0, 0, 0, 0, 32'hCAFE_BABE, 1, 32'hCAFE_BABE);
    // Rows 31..42: streaming reads 0..7, word 3 rewritten the cycle after its read.
    add(0, 0, 1, 3, 32'h0000_0033, 2'b11, 0, 32'hCAFE_BABE, 0, 32'hCAFE_BABE);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 32'hCAFE_BABE);
    add(1, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    add(1, 2, 0, 0, 0, 0, 1, 0, 1, 0);
    add(1, 3, 0, 0, 0, 0, 1, 32'h0000_0033, 1, 0);
    add(1, 4, 1, 3, 32'h0000_BEEF, 2'b11, 1, 0, 1, 32'h0000_0033);
    add(1, 5, 0, 0, 0, 0, 1, 32'h1122_CCDD, 1, 0);
    add(1, 6, 0, 0, 0, 0, 1, 32'hCAFE_BABE, 1, 32'h1122_CCDD);
    add(1, 7, 0, 0, 0, 0, 1, 32'h3333_2222, 1, 32'hCAFE_BABE);
    add(0, 0, 0, 0, 0, 0, 0, 32'h3333_2222, 1, 32'h3333_2222);
    add(1, 3, 0, 0, 0, 0, 1, 32'h0000_BEEF, 0, 32'h3333_2222);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0000_BEEF, 1, 32'h0000_BEEF);
    // Rows 43..46: after the final clear every word reads zero.
    add(1, 6, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 5, 0, 0, 0, 0, 1, 0, 1, 0);
    add(1, 2, 0, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rv1", {31'd0, rvalid1}, 32'd0);
    chk("rst_rd1", rdata1, 32'd0);
    chk("rst_rv2", {31'd0, rvalid2}, 32'd0);
    chk("rst_rd2", rdata2, 32'd0);
    chk("rst_busy1", {31'd0, busy1}, 32'd1);
    chk("rst_busy2", {31'd0, busy2}, 32'd1);

    @(negedge clk);
    release_and_clear("clr1");
    run_rows(0, 43);

    // Reset with a read in flight in the L=2 pipe.
    ren = 1'b1; raddr = 4'd5;
    @(posedge clk); #1;
    ren = 1'b0;
    chk("infl_rv1", {31'd0, rvalid1}, 32'd1);
    chk("infl_rd1", rdata1, 32'h1122_CCDD);
    chk("infl_rv2", {31'd0, rvalid2}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_rv1", {31'd0, rvalid1}, 32'd0);
    chk("arst_rd1", rdata1, 32'd0);
    chk("arst_rv2", {31'd0, rvalid2}, 32'd0);
    chk("arst_rd2", rdata2, 32'd0);
    chk("arst_busy", {31'd0, busy1}, 32'd1);
    @(posedge clk); #1;
    chk("arst_flush_rv2", {31'd0, rvalid2}, 32'd0);

    // Abort a clear at address 9, then confirm the restart takes a full sweep.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy_before", {31'd0, busy1}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy_rst", {31'd0, busy2}, 32'd1);
    @(negedge clk);
    release_and_clear("clr2");
    run_rows(43, 47);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
